mult_8x8_seq_ctrl: RTL and testbench
====================================

Name: mult_8x8_seq_ctrl

Overview:
- Iterative 8x8 multiply controller that time-shares one external 4x4 sub-multiplier across the four nibble partial products.
- Issues one quadrant per cycle, accumulates with shifts into a 16-bit result, and returns it over a valid/ready handshake.
- Per-quadrant R1/R2 variant selection is driven out on sub_sel so the 8x8 error configuration can be set without duplicating 4x4 hardware.

Parameters:
- QUAD_SEL, 4'b1100, bit k set selects the R1 variant for quadrant k; clear selects R2. Quadrant 0=AL*BL, 1=AL*BH, 2=AH*BL, 3=AH*BH.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operands a/b valid
- in_ready  out  1  controller can accept operands
- a  in  8  multiplicand
- b  in  8  multiplier
- out_valid  out  1  r holds the finished product
- out_ready  in  1  consumer accepts r
- r  out  16  product
- busy  out  1  state is not IDLE
- sub_en  out  1  quadrant issued this cycle
- sub_a  out  4  nibble of a for the sub-multiplier
- sub_b  out  4  nibble of b for the sub-multiplier
- sub_sel  out  1  1 = R1 variant, 0 = R2 variant
- sub_r  in  8  combinational sub-multiplier result for the current sub_a/sub_b/sub_sel

Behaviour:
- Reset (async, any state): state=IDLE, step=0, a/b regs=0, acc=0.
  - Outputs: in_ready=1, out_valid=0, r=0, busy=0, sub_en=0, sub_a=0, sub_b=0, sub_sel=0.
- States:
  - IDLE: in_ready=1. On in_valid, latch a and b, clear acc and step, go to BUSY.
  - BUSY: in_ready=0, sub_en=1.
    - Drive quadrant step: sub_a = step[1] ? AH : AL; sub_b = step[0] ? BH : BL; sub_sel = QUAD_SEL[step].
    - Each cycle, acc += sub_r << shift, where shift = 0, 4, 4, 8 for steps 0..3. acc is 16 bits; its true maximum fits in 16 bits, so overflow is not possible.
    - After step 3, go to DONE.
  - DONE: out_valid=1, r=acc, held stable until out_ready. On out_ready go to IDLE.
- Latency: handshake at cycle 0; BUSY occupies cycles 1-4; out_valid is first high at cycle 5.
- Throughput: one operation per 6 cycles with out_ready held high.
- No input accept in DONE, even when out_ready is high in the same cycle.
- Outside BUSY: sub_en=0 and sub_a/sub_b/sub_sel are driven 0.
- a and b inputs are ignored while in_ready=0.
- Reset asserted mid-operation aborts it. No partial result is emitted and out_valid stays 0.

Optional Feature:
- Macro MULT_ZERO_SKIP_EN.
- Defined:
  - At accept, compute skip[k]=1 when either nibble of quadrant k is zero.
  - BUSY visits only non-skipped quadrants, in ascending order. Skipped quadrants contribute 0 and take no cycles.
  - If all four are skipped, go IDLE -> DONE directly; out_valid is high at cycle 1.
  - Latency is 1 + number of non-skipped quadrants.
- Not defined: all four quadrants are always issued; latency is fixed at 5.

Test Plan:
- Exact 4x4 bench model, a=0xFF, b=0xFF, out_ready=1: out_valid rises at cycle 5; r=0xFE01; in_ready returns at cycle 6.
- a=0x12, b=0x34: BUSY cycles show (sub_a, sub_b, sub_sel) = (2,4,0), (2,3,0), (1,4,1), (1,3,1); r=0x03A8.
- Backpressure, a=0x0A, b=0x0B: out_ready held low 3 cycles after out_valid → r=0x006E held stable, in_ready=0; a new in_valid is ignored until the DONE→IDLE handshake.
- Reset pulsed at BUSY step 2 → all outputs at reset values immediately. Next op a=0x03, b=0x07 → r=0x0015, with no contamination from the aborted accumulation.
- With MULT_ZERO_SKIP_EN, a=0x05, b=0x30: only quadrant 1 issued (sub_a=5, sub_b=3); out_valid at cycle 2; r=0x00F0.
- With MULT_ZERO_SKIP_EN, a=0x00, b=0x9C: sub_en never asserted; out_valid at cycle 1; r=0x0000. Without the macro: 4 BUSY cycles, r=0x0000.

Source files
------------

// File: rtl/mult_8x8_seq_ctrl_if.sv
// Operand/result handshake and sub-multiplier bus for mult_8x8_seq_ctrl.
// The slave modport is the controller side; the master modport is the environment side.
interface mult_8x8_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        busy;
  logic        sub_en;
  logic [3:0]  sub_a;
  logic [3:0]  sub_b;
  logic        sub_sel;
  logic [7:0]  sub_r;

  modport slave (
    input  in_valid, a, b, out_ready, sub_r,
    output in_ready, out_valid, r, busy, sub_en, sub_a, sub_b, sub_sel
  );

  modport master (
    output in_valid, a, b, out_ready, sub_r,
    input  in_ready, out_valid, r, busy, sub_en, sub_a, sub_b, sub_sel
  );
endinterface

// File: rtl/mult_8x8_seq_ctrl.sv
// 8x8 multiply controller time-sharing one external 4x4 sub-multiplier over four quadrants.
// Optional MULT_ZERO_SKIP_EN: quadrants with a zero nibble are skipped and cost no cycles.
module mult_8x8_seq_ctrl #(
  parameter logic [3:0] QUAD_SEL = 4'b1100
) (
  input logic                clk,
  input logic                rst,
  mult_8x8_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [3:0]  pend_q, pend_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] r_q, r_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        sub_en_q, sub_en_d;
  logic [3:0]  sub_a_q, sub_a_d;
  logic [3:0]  sub_b_q, sub_b_d;
  logic        sub_sel_q, sub_sel_d;

  logic        issue;
  logic [3:0]  nxt_mask;
  logic [1:0]  nxt_quad;

  function automatic logic [3:0] nib_a(input logic [7:0] v, input logic [1:0] q);
    return q[1] ? v[7:4] : v[3:0];
  endfunction

  function automatic logic [3:0] nib_b(input logic [7:0] v, input logic [1:0] q);
    return q[0] ? v[7:4] : v[3:0];
  endfunction

  // Lowest pending quadrant wins, so quadrants are visited in ascending order.
  function automatic logic [1:0] first_quad(input logic [3:0] m);
    logic [1:0] q;
    q = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) q = 2'(k);
    end
    return q;
  endfunction

  function automatic logic [15:0] shift_pp(input logic [7:0] pp, input logic [1:0] q);
    logic [15:0] s;
    case (q)
      2'd0:    s = {8'd0, pp};
      2'd1,
      2'd2:    s = {4'd0, pp, 4'd0};
      default: s = {pp, 8'd0};
    endcase
    return s;
  endfunction

  function automatic logic [3:0] issue_mask(input logic [7:0] va, input logic [7:0] vb);
    logic [3:0] m;
`ifdef MULT_ZERO_SKIP_EN
    for (int k = 0; k < 4; k++) begin
      m[k] = (nib_a(va, 2'(k)) != 4'd0) && (nib_b(vb, 2'(k)) != 4'd0);
    end
`else
    m = 4'b1111;
    if (va == vb) m = 4'b1111;
`endif
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pend_d      = pend_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    r_d         = r_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    sub_en_d    = 1'b0;
    sub_a_d     = 4'd0;
    sub_b_d     = 4'd0;
    sub_sel_d   = 1'b0;
    issue       = 1'b0;
    nxt_mask    = 4'd0;
    nxt_quad    = 2'd0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          acc_d    = 16'd0;
          step_d   = 2'd0;
          nxt_mask = issue_mask(bus.a, bus.b);
          issue    = 1'b1;
        end
      end
      BUSY: begin
        // sub_r answers the quadrant registered onto sub_a/sub_b last edge, i.e. step_q.
        acc_d    = acc_q + shift_pp(bus.sub_r, step_q);
        nxt_mask = pend_q;
        issue    = 1'b1;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      in_ready_d = 1'b0;
      busy_d     = 1'b1;
      if (nxt_mask != 4'd0) begin
        nxt_quad  = first_quad(nxt_mask);
        state_d   = BUSY;
        step_d    = nxt_quad;
        pend_d    = nxt_mask & ~(4'b0001 << nxt_quad);
        sub_en_d  = 1'b1;
        sub_a_d   = nib_a(a_d, nxt_quad);
        sub_b_d   = nib_b(b_d, nxt_quad);
        sub_sel_d = QUAD_SEL[nxt_quad];
      end else begin
        state_d     = DONE;
        pend_d      = 4'd0;
        out_valid_d = 1'b1;
        r_d         = acc_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      step_q      <= 2'd0;
      pend_q      <= 4'd0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      acc_q       <= 16'd0;
      r_q         <= 16'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sub_en_q    <= 1'b0;
      sub_a_q     <= 4'd0;
      sub_b_q     <= 4'd0;
      sub_sel_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      pend_q      <= pend_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sub_en_q    <= sub_en_d;
      sub_a_q     <= sub_a_d;
      sub_b_q     <= sub_b_d;
      sub_sel_q   <= sub_sel_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.r         = r_q;
  assign bus.busy      = busy_q;
  assign bus.sub_en    = sub_en_q;
  assign bus.sub_a     = sub_a_q;
  assign bus.sub_b     = sub_b_q;
  assign bus.sub_sel   = sub_sel_q;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed bench for mult_8x8_seq_ctrl with an exact 4x4 sub-multiplier model and a result scoreboard.
// Expectations follow MULT_ZERO_SKIP_EN when the bench is built with it.
module tb_mult_8x8_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_q[$];
  logic [8:0]  trace[$];

  mult_8x8_seq_ctrl_if bus();

  mult_8x8_seq_ctrl #(.QUAD_SEL(4'b1100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.sub_r = {4'd0, bus.sub_a} * {4'd0, bus.sub_b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_r"},         32'(bus.r),         32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_sub_en"},    32'(bus.sub_en),    32'd0);
    chk({tag, "_sub_a"},     32'(bus.sub_a),     32'd0);
    chk({tag, "_sub_b"},     32'(bus.sub_b),     32'd0);
    chk({tag, "_sub_sel"},   32'(bus.sub_sel),   32'd0);
  endtask

  task automatic start_op(input logic [7:0] ia, input logic [7:0] ib);
    bus.a        = ia;
    bus.b        = ib;
    bus.in_valid = 1'b1;
    exp_q.push_back(16'(ia) * 16'(ib));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called in cycle 1 (just after the accepting edge); returns at the first out_valid cycle.
  task automatic wait_done(input string tag, input int exp_lat, input int exp_nsub);
    int lat;
    logic [15:0] expr;
    lat = 1;
    trace.delete();
    while (!bus.out_valid && lat < 30) begin
      if (bus.sub_en) trace.push_back({bus.sub_a, bus.sub_b, bus.sub_sel});
      tick();
      lat++;
    end
    chk({tag, "_done_seen"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_nsub"}, 32'(trace.size()), 32'(exp_nsub));
    chk({tag, "_done_in_ready"}, 32'(bus.in_ready), 32'd0);
    expr = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
    chk({tag, "_r"}, 32'(bus.r), 32'(expr));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    tick();
    chk({tag, "_hs_in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, "_hs_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_hs_busy"},      32'(bus.busy),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] exp_tr [4];
    logic [8:0] got;
    int lat_skip2;
    int nsub_skip1;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.a        = 8'd0;
    bus.b        = 8'd0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk_reset("rst_hold");
    rst = 1'b0;
    tick();
    chk_reset("rst_release");

    // Full-scale operands: no zero nibbles, four quadrants in every build.
    start_op(8'hFF, 8'hFF);
    wait_done("ff", 5, 4);
    handshake("ff");

    // Quadrant order and variant select.
    start_op(8'h12, 8'h34);
    wait_done("q1234", 5, 4);
    exp_tr[0] = {4'h2, 4'h4, 1'b0};
    exp_tr[1] = {4'h2, 4'h3, 1'b0};
    exp_tr[2] = {4'h1, 4'h4, 1'b1};
    exp_tr[3] = {4'h1, 4'h3, 1'b1};
    for (int i = 0; i < 4; i++) begin
      got = (trace.size() > i) ? trace[i] : 9'h1FF;
      chk($sformatf("q1234_trace%0d", i), 32'(got), 32'(exp_tr[i]));
    end
    handshake("q1234");

`ifdef MULT_ZERO_SKIP_EN
    lat_skip2  = 2;
    nsub_skip1 = 1;
`else
    lat_skip2  = 5;
    nsub_skip1 = 4;
`endif

    // Backpressure in DONE; new operands and in_valid must be ignored until released.
    bus.out_ready = 1'b0;
    start_op(8'h0A, 8'h0B);
    wait_done("bp", lat_skip2, nsub_skip1);
    bus.a = 8'h55;
    bus.b = 8'h66;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("bp_hold%0d_r", i), 32'(bus.r), 32'h006E);
      chk($sformatf("bp_hold%0d_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", i), 32'(bus.in_ready), 32'd0);
    end
    // in_valid stays high through the releasing edge: DONE must not accept it.
    handshake("bp");
    bus.in_valid = 1'b0;
    tick();
    chk("bp_idle_busy", 32'(bus.busy), 32'd0);
    chk("bp_idle_sub_en", 32'(bus.sub_en), 32'd0);

    // Abort at step 2 with asynchronous reset.
    start_op(8'hAB, 8'hCD);
    tick();
    tick();
    chk("abort_step2_sub_a", 32'(bus.sub_a), 32'hA);
    chk("abort_step2_sub_b", 32'(bus.sub_b), 32'hD);
    chk("abort_step2_sub_sel", 32'(bus.sub_sel), 32'd1);
    exp_q.delete();
    #2;
    rst = 1'b1;
    #1;
    chk_reset("abort_async");
    tick();
    rst = 1'b0;
    chk_reset("abort_held");
    start_op(8'h03, 8'h07);
    wait_done("post_abort", lat_skip2, nsub_skip1);
    handshake("post_abort");

    // Zero-nibble operands.
`ifdef MULT_ZERO_SKIP_EN
    start_op(8'h05, 8'h30);
    wait_done("z0530", 2, 1);
    got = (trace.size() > 0) ? trace[0] : 9'h1FF;
    chk("z0530_quad", 32'(got), 32'({4'h5, 4'h3, 1'b0}));
    handshake("z0530");
    start_op(8'h00, 8'h9C);
    wait_done("z009c", 1, 0);
    handshake("z009c");
`else
    start_op(8'h05, 8'h30);
    wait_done("z0530", 5, 4);
    handshake("z0530");
    start_op(8'h00, 8'h9C);
    wait_done("z009c", 5, 4);
    handshake("z009c");
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
